// File: rtl/clr_gen.sv
// clr_gen: drives the active-high asynchronous clear lines of downstream flops.
// All clears assert at once when notCLR falls. Release is synchronised to C,
// waits out a hold period, then drops the clear lines one at a time in index
// order. A four-phase SREQ/SACK handshake re-runs the sequence from software.
module clr_gen #(
  parameter int N_OUT       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic             C,
  input  logic             notCLR,
  input  logic             SREQ,
  output logic             SACK,
  output logic [N_OUT-1:0] CLR_OUT,
  output logic             READY
);

  // The counter is shared by HOLD and RELEASE, so it is sized for the longer
  // of the two periods. It is reset at its terminal value and never wraps.
  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN,
    ST_SOFT
  } state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [N_OUT-1:0]   clr_reg, clr_next;
  logic               ready_reg, ready_next;
  logic               sack_reg, sack_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic               sync_rel;
  logic [N_OUT-1:0]   clr_shift;

  // Deassertion synchroniser: clears at once with notCLR and shifts in ones
  // afterwards, so the release seen by the FSM is aligned to C.
  always_ff @(posedge C or negedge notCLR) begin
    if (!notCLR) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rel = sync_reg[SYNC_STAGES-1];

  // Shifting the clear vector left drops the lowest still-set bit. Because
  // the vector is always a contiguous run of ones at the top, this enforces
  // index-ordered release. A zero result means the last bit has just gone.
  assign clr_shift = clr_reg << 1;

  // State, counter and registered outputs; notCLR forces the asserted state.
  always_ff @(posedge C or negedge notCLR) begin
    if (!notCLR) begin
      state_reg <= ST_ASSERT;
      cnt_reg   <= '0;
      clr_reg   <= '1;
      ready_reg <= 1'b0;
      sack_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      clr_reg   <= clr_next;
      ready_reg <= ready_next;
      sack_reg  <= sack_next;
    end
  end

  // Next-state and next-output logic for the release/soft-reset sequence.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clr_next   = clr_reg;
    ready_next = ready_reg;
    sack_next  = sack_reg;
    case (state_reg)
      ST_ASSERT: begin
        if (sync_rel) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          cnt_next = '0;
          clr_next = clr_shift;
          if (clr_shift == '0) begin
            // Single-output build: bit 0 was the last one.
            state_next = ST_RUN;
            ready_next = 1'b1;
          end else begin
            state_next = ST_RELEASE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next = '0;
          clr_next = clr_shift;
          if (clr_shift == '0) begin
            state_next = ST_RUN;
            ready_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        if (SREQ) begin
          state_next = ST_SOFT;
          clr_next   = '1;
          ready_next = 1'b0;
          sack_next  = 1'b1;
        end
      end
      ST_SOFT: begin
        if (!SREQ) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
          sack_next  = 1'b0;
        end
      end
      default: begin
        state_next = ST_ASSERT;
        cnt_next   = '0;
        clr_next   = '1;
        ready_next = 1'b0;
        sack_next  = 1'b0;
      end
    endcase
  end

  assign CLR_OUT = clr_reg;
  assign READY   = ready_reg;
  assign SACK    = sack_reg;

endmodule
